// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and frame geometry.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_RX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } uart_rx_state_t;

`ifdef UART_RX_PARITY_EN
   // Even parity: the transmitted parity bit equals the XOR of the data bits.
   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction
`endif

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
// RESET_VAL sets what both stages hold while reset is asserted.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver (8E1 when UART_RX_PARITY_EN is defined) feeding the keyboard buffer.
// Good frames strobe rx_done with rx_data; bad stop or parity strobes frame_err instead.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_done,
   output logic                      frame_err,
   output logic                      busy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int HALF = (CLKS_PER_BIT - 1) / 2;
   localparam logic [TW-1:0] START_LAST = TW'(HALF - 1);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);

   logic rx_s;

   uart_rx_state_t              state_q, state_d;
   logic [TW-1:0]               timer_q, timer_d;
   logic [2:0]                  idx_q, idx_d;
   logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
   logic [UART_DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                        done_q, done_d;
   logic                        err_q, err_d;
   logic                        busy_q, busy_d;
   logic                        bit_end;
   logic                        stop_ok;
`ifdef UART_RX_PARITY_EN
   logic                        par_err_q, par_err_d;
`endif

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (reset),
      .d   (rx),
      .q   (rx_s)
   );

   // A sample is taken on the edge where the timer would reach its target,
   // so the START sample lands HALF cycles and each bit CLKS_PER_BIT cycles later.
   assign bit_end = (timer_q == BIT_LAST);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      busy_d    = (state_q != ST_IDLE);
      stop_ok   = rx_s;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
      stop_ok   = rx_s && !par_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
            end
         end

         ST_START: begin
            if (timer_q == START_LAST) begin
               timer_d = '0;
               idx_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               timer_d = '0;
               shift_d[idx_q] = rx_s;
               if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               timer_d   = '0;
               par_err_d = (rx_s != even_parity(shift_q));
               state_d   = ST_STOP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
`endif

         ST_STOP: begin
            if (bit_end) begin
               timer_d = '0;
               state_d = ST_IDLE;
               if (stop_ok) begin
                  rx_data_d = shift_q;
                  done_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_done   = done_q;
   assign frame_err = err_q;
   assign busy      = busy_q;

   // The buffer relies on a frame producing either data or an error, never both.
   a_done_err_exclusive : assert property (@(posedge clk) disable iff (reset) !(done_q && err_q));

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16, table-driven frames plus corner sequences.
// Define UART_RX_PARITY_EN for both bench and RTL to exercise the 8E1 build.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int H = (CPB - 1) / 2;
   localparam int STOP_LOW = 12;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 10;
`else
   localparam int FRAME_BITS = 9;
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      logic       par_flip;
      logic       exp_done;
      logic [7:0] exp_data;
   } vec_t;

   typedef struct {
      int         cyc;
      logic       is_done;
      logic [7:0] data;
      logic       busy_at;
   } evt_t;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   int   cyc;
   int   errors;
   int   checks;
   logic pend_done;
   logic busy_after;
   evt_t evq[$];
   vec_t vecs[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse with its cycle stamp, plus busy one cycle after each rx_done.
   initial pend_done = 1'b0;
   initial busy_after = 1'bx;
   always @(negedge clk) begin
      if (pend_done) begin
         busy_after = busy;
         pend_done  = 1'b0;
      end
      if (rx_done && frame_err) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_err_exclusive: both high at cycle %0d, required at most one", cyc);
      end
      if (rx_done || frame_err) begin
         evq.push_back('{cyc, rx_done, rx_data, busy});
         if (rx_done) pend_done = 1'b1;
      end
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame from a negedge; c0 is the cycle stamp of the start-bit fall.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                input logic par_flip, output int c0);
      c0 = cyc;
      rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         waitCycles(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^data) ^ par_flip;
      waitCycles(CPB);
`else
      if (par_flip) $display("[TB] note: parity flip ignored in 8N1 build");
`endif
      if (stop_bit) begin
         rx = 1'b1;
         waitCycles(CPB);
      end else begin
         rx = 1'b0;
         waitCycles(STOP_LOW);
         rx = 1'b1;
         waitCycles(CPB - STOP_LOW);
      end
      rx = 1'b1;
      waitCycles(CPB);
   endtask

   task automatic checkOutput(input vec_t v, input int c0, input string tag);
      evt_t e;
      checkVal({tag, " pulse_count"}, evq.size(), 1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         checkVal({tag, " pulse_is_done"}, e.is_done, v.exp_done);
         checkVal({tag, " pulse_cycle"}, e.cyc, c0 + 3 + H + FRAME_BITS * CPB);
         if (v.exp_done) begin
            checkVal({tag, " data_on_done"}, e.data, v.exp_data);
            checkVal({tag, " busy_on_done"}, e.busy_at, 1'b1);
            checkVal({tag, " busy_after_done"}, busy_after, 1'b0);
         end
      end
      checkVal({tag, " rx_data_held"}, rx_data, v.exp_data);
      evq.delete();
   endtask

   initial begin
      int c0;
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      rx     = 1'b1;

      vecs.push_back('{8'h68, 1'b1, 1'b0, 1'b1, 8'h68});
      vecs.push_back('{8'h68, 1'b1, 1'b0, 1'b1, 8'h68});
      vecs.push_back('{8'h65, 1'b1, 1'b0, 1'b1, 8'h65});
      vecs.push_back('{8'h6C, 1'b1, 1'b0, 1'b1, 8'h6C});
      vecs.push_back('{8'h6C, 1'b1, 1'b0, 1'b1, 8'h6C});
      vecs.push_back('{8'h6F, 1'b1, 1'b0, 1'b1, 8'h6F});
      vecs.push_back('{8'h20, 1'b1, 1'b0, 1'b1, 8'h20});
      vecs.push_back('{8'h77, 1'b1, 1'b0, 1'b1, 8'h77});
      vecs.push_back('{8'h6F, 1'b1, 1'b0, 1'b1, 8'h6F});
      vecs.push_back('{8'h72, 1'b1, 1'b0, 1'b1, 8'h72});
      vecs.push_back('{8'h6C, 1'b1, 1'b0, 1'b1, 8'h6C});
      vecs.push_back('{8'h64, 1'b1, 1'b0, 1'b1, 8'h64});
      vecs.push_back('{8'h65, 1'b0, 1'b0, 1'b0, 8'h64});
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{8'h6C, 1'b1, 1'b0, 1'b1, 8'h6C});
      vecs.push_back('{8'h6C, 1'b1, 1'b1, 1'b0, 8'h6C});
`endif

      waitCycles(3);
      checkVal("reset rx_data", rx_data, 8'h00);
      checkVal("reset rx_done", rx_done, 1'b0);
      checkVal("reset frame_err", frame_err, 1'b0);
      checkVal("reset busy", busy, 1'b0);
      reset = 1'b0;
      waitCycles(CPB);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, c0);
         checkOutput(vecs[i], c0, $sformatf("vec%0d", i));
      end

      // Five-cycle low glitch: START samples high and returns to IDLE silently.
      waitCycles(2 * CPB);
      evq.delete();
      c0 = cyc;
      rx = 1'b0;
      waitCycles(5);
      rx = 1'b1;
      waitCycles(1);
      checkVal("glitch busy_high", busy, 1'b1);
      waitCycles(4);
      checkVal("glitch busy_at_sample", busy, 1'b1);
      waitCycles(1);
      checkVal("glitch busy_cleared", busy, 1'b0);
      checkVal("glitch cycle_ref", cyc, c0 + 11);
      waitCycles(3 * CPB);
      checkVal("glitch no_pulse", evq.size(), 0);

      // Reset in the middle of data bit 4 of 0x72, then a clean 0x65.
      c0 = cyc;
      rx = 1'b0;
      waitCycles(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = logic'((8'h72 >> i) & 8'h01);
         waitCycles(CPB);
      end
      rx = 1'b1;
      waitCycles(CPB / 2);
      checkVal("midreset busy_before", busy, 1'b1);
      reset = 1'b1;
      waitCycles(1);
      checkVal("midreset rx_data", rx_data, 8'h00);
      checkVal("midreset busy", busy, 1'b0);
      checkVal("midreset rx_done", rx_done, 1'b0);
      waitCycles(3);
      reset = 1'b0;
      waitCycles(3 * CPB);
      checkVal("midreset no_pulse", evq.size(), 0);
      evq.delete();
      applyStimulus(8'h65, 1'b1, 1'b0, c0);
      checkOutput('{8'h65, 1'b1, 1'b0, 1'b1, 8'h65}, c0, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
